qk_score_engine: RTL

- Parametrised successor to the fixed 128x2048 QK score array.
- Stores K vectors as rows of an internal memory. Computes the signed dot product of an accepted Q vector with keys 0..seq_len-1, LANES elements per cycle.
- Streams one score per key over a valid/ready output instead of a full-width result bus.
- Sits between the Q/K projection stage and softmax in the Score path.

---
 rtl/qk_score_engine.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/qk_score_engine.sv
// qk_score_engine: streaming signed Q.K score engine.
// Keys are stored as memory rows; each accepted query is dotted with keys 0..n-1,
// LANES elements per cycle, and one saturated score per key leaves on a valid/ready port.
//
// Optional build macro: CAUSAL_MASK_EN (keys above the latched q_pos score as the
// most negative value without running the multiply-accumulate).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   k_valid/k_ready       K row write request (k_addr row, k_data vector)
//   q_valid/q_ready       Q request (q_data vector, seq_len keys, q_pos query position)
//   s_valid/s_ready       score stream: s_data score, s_index key, s_last final key
//   done                  one-cycle pulse when a query completes
//   busy                  engine is not idle
module qk_score_engine #(
    parameter int DATA_W    = 8,
    parameter int D_K       = 128,
    parameter int LANES     = 16,
    parameter int MAX_SEQ   = 2048,
    parameter int ADDR_W    = 11,
    parameter int ACC_W     = 2*DATA_W + $clog2(D_K),
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    k_valid,
    output logic                    k_ready,
    input  logic [ADDR_W-1:0]       k_addr,
    input  logic [DATA_W*D_K-1:0]   k_data,
    input  logic                    q_valid,
    output logic                    q_ready,
    input  logic [DATA_W*D_K-1:0]   q_data,
    input  logic [ADDR_W:0]         seq_len,
    input  logic [ADDR_W-1:0]       q_pos,
    output logic                    s_valid,
    input  logic                    s_ready,
    output logic signed [OUT_W-1:0] s_data,
    output logic [ADDR_W-1:0]       s_index,
    output logic                    s_last,
    output logic                    done,
    output logic                    busy
);

    localparam int C       = D_K / LANES;
    localparam int CW      = (C > 1) ? $clog2(C) : 1;
    localparam int CHUNK_W = LANES * DATA_W;
    localparam int MEM_D   = MAX_SEQ * C;
    localparam int MEM_AW  = (MEM_D > 1) ? $clog2(MEM_D) : 1;
    localparam int PROD_W  = 2 * DATA_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] KWR  = 2'd1;
    localparam logic [1:0] MAC  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
    localparam logic signed [OUT_W-1:0] S_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [ADDR_W:0]         N_MAX  = (ADDR_W+1)'(MAX_SEQ);
    localparam logic [ADDR_W:0]         N_ONE  = (ADDR_W+1)'(1);

    logic [1:0]               r_state;
    logic [DATA_W*D_K-1:0]    r_k_data;
    logic [ADDR_W-1:0]        r_k_addr;
    logic                     r_k_wen;
    logic [DATA_W*D_K-1:0]    r_q_data;
    logic [ADDR_W:0]          r_n;
    logic [ADDR_W-1:0]        r_key;
    logic [CW-1:0]            r_chunk;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [OUT_W-1:0]  r_s_data;
    logic [ADDR_W-1:0]        r_s_index;
    logic                     r_s_last;
    logic                     r_done;

    // Row r, chunk c lives at word r*C + c.
    logic [CHUNK_W-1:0]       r_mem [MEM_D];

    logic                     w_k_acc;
    logic                     w_q_acc;
    logic                     w_chunk_last;
    logic                     w_key_last;
    logic                     w_masked;
    logic [MEM_AW-1:0]        w_raddr;
    logic [MEM_AW-1:0]        w_waddr;
    logic [CHUNK_W-1:0]       w_mem_rd;
    logic [CHUNK_W-1:0]       w_q_chunk;
    logic [CHUNK_W-1:0]       w_k_chunk;
    logic signed [ACC_W-1:0]  w_lane_sum;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [OUT_W-1:0]  w_sat;
    logic [ADDR_W:0]          w_n_next;

    // K has priority over Q when both request in the same idle cycle.
    assign w_k_acc = (r_state == IDLE) && k_valid;
    assign w_q_acc = (r_state == IDLE) && q_valid && !k_valid;

    assign w_chunk_last = (r_chunk == CW'(C - 1));
    assign w_key_last   = ({1'b0, r_key} == (r_n - N_ONE));
    assign w_n_next     = (seq_len > N_MAX) ? N_MAX : seq_len;

    assign w_raddr = MEM_AW'(32'(r_key) * C + 32'(r_chunk));
    assign w_waddr = MEM_AW'(32'(r_k_addr) * C + 32'(r_chunk));

    assign w_mem_rd  = r_mem[w_raddr];
    assign w_q_chunk = r_q_data[32'(r_chunk)*CHUNK_W +: CHUNK_W];
    assign w_k_chunk = r_k_data[32'(r_chunk)*CHUNK_W +: CHUNK_W];

`ifdef CAUSAL_MASK_EN
    logic [ADDR_W-1:0] r_q_pos;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q_pos <= '0;
        end else if (w_q_acc) begin
            r_q_pos <= q_pos;
        end
    end

    assign w_masked = (r_key > r_q_pos);
`else
    logic w_unused_qpos;

    assign w_unused_qpos = ^q_pos;
    assign w_masked      = 1'b0;
`endif

    // Signed sum of one chunk of LANES products, widened to the accumulator.
    always_comb begin
        logic signed [DATA_W-1:0] w_qe;
        logic signed [DATA_W-1:0] w_ke;
        logic signed [PROD_W-1:0] w_prod;
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_qe       = w_q_chunk[l*DATA_W +: DATA_W];
            w_ke       = w_mem_rd[l*DATA_W +: DATA_W];
            w_prod     = PROD_W'(w_qe) * PROD_W'(w_ke);
            w_lane_sum = w_lane_sum + ACC_W'(w_prod);
        end
    end

    assign w_acc_sum = r_acc + w_lane_sum;
    // Arithmetic shift floors toward negative infinity.
    assign w_shifted = w_acc_sum >>> OUT_SHIFT;

    always_comb begin
        w_sat = OUT_W'(w_shifted);
        if (w_shifted > SAT_HI) begin
            w_sat = OUT_W'(SAT_HI);
        end else if (w_shifted < SAT_LO) begin
            w_sat = OUT_W'(SAT_LO);
        end
    end

    // Wide operand registers carry no reset; they are only read after a capture.
    always_ff @(posedge clk) begin
        if (w_k_acc) begin
            r_k_data <= k_data;
        end
        if (w_q_acc) begin
            r_q_data <= q_data;
        end
    end

    // K memory is not reset; a write cut short by reset leaves a mixed row.
    always_ff @(posedge clk) begin
        if ((r_state == KWR) && r_k_wen) begin
            r_mem[w_waddr] <= w_k_chunk;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_k_addr  <= '0;
            r_k_wen   <= 1'b0;
            r_n       <= '0;
            r_key     <= '0;
            r_chunk   <= '0;
            r_acc     <= '0;
            r_s_data  <= '0;
            r_s_index <= '0;
            r_s_last  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_k_acc) begin
                        r_k_addr <= k_addr;
                        r_k_wen  <= (32'(k_addr) < 32'(MAX_SEQ));
                        r_chunk  <= '0;
                        r_state  <= KWR;
                    end else if (w_q_acc) begin
                        r_n     <= w_n_next;
                        r_key   <= '0;
                        r_acc   <= '0;
                        r_chunk <= '0;
                        if (seq_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= MAC;
                        end
                    end
                end
                KWR: begin
                    if (w_chunk_last) begin
                        r_chunk <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_chunk <= r_chunk + 1'b1;
                    end
                end
                MAC: begin
                    if (w_masked) begin
                        r_s_data  <= S_MIN;
                        r_s_index <= r_key;
                        r_s_last  <= w_key_last;
                        r_state   <= OUT;
                    end else if (w_chunk_last) begin
                        r_acc     <= w_acc_sum;
                        r_s_data  <= w_sat;
                        r_s_index <= r_key;
                        r_s_last  <= w_key_last;
                        r_chunk   <= '0;
                        r_state   <= OUT;
                    end else begin
                        r_acc   <= w_acc_sum;
                        r_chunk <= r_chunk + 1'b1;
                    end
                end
                OUT: begin
                    if (s_ready) begin
                        if (r_s_last) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_key   <= r_key + 1'b1;
                            r_acc   <= '0;
                            r_chunk <= '0;
                            r_state <= MAC;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign k_ready = (r_state == IDLE);
    assign q_ready = (r_state == IDLE);
    assign busy    = (r_state != IDLE);
    assign s_valid = (r_state == OUT);
    assign s_data  = r_s_data;
    assign s_index = r_s_index;
    assign s_last  = r_s_last;
    assign done    = r_done;

endmodule
